// File: rtl/rptr_empty_level.sv
// Read-side pointer, empty/almost-empty flags and fill level for a Gray-pointer async FIFO; all flags registered (1 r_clk).
// Reads while empty are ignored and flagged in a sticky underflow bit; no backpressure beyond empty.
module rptr_empty_level #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  r_clk,
    input  logic                  r_rstn,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  clr_uflow,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   r_level,
    output logic                  underflow
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_bin_nxt;
    logic [PW-1:0] rptr_gray_nxt;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_nxt;
    logic          rd_fire;

    // Gated by the registered empty so r_en never reaches a flag combinationally.
    assign rd_fire       = r_en & ~empty;
    assign rptr_bin_nxt  = rptr_bin + {{ADDR_WIDTH{1'b0}}, rd_fire};
    assign rptr_gray_nxt = rptr_bin_nxt ^ (rptr_bin_nxt >> 1);
    assign r_addr        = rptr_bin[ADDR_WIDTH-1:0];

    always_comb begin
        wbin         = '0;
        wbin[PW-1]   = rq2_wptr[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
    end

    // Modulo subtraction keeps a full FIFO (MSBs differ) at exactly 2^ADDR_WIDTH.
    assign level_nxt = wbin - rptr_bin_nxt;

    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            rptr_bin     <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            r_level      <= '0;
            underflow    <= 1'b0;
        end else begin
            rptr_bin     <= rptr_bin_nxt;
            rptr_gray    <= rptr_gray_nxt;
            empty        <= (rptr_gray_nxt == rq2_wptr);
            almost_empty <= (level_nxt <= ae_thresh);
            r_level      <= level_nxt;
            if (r_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_uflow) begin
                underflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rptr_empty_level.sv
// Bench for rptr_empty_level: vector table plus hand-written full, mid-reset and wrap sequences.
module tb_rptr_empty_level;
    localparam int AW = 4;

    logic          r_clk = 1'b0;
    logic          r_rstn = 1'b1;
    logic          r_en = 1'b0;
    logic          clr_uflow = 1'b0;
    logic [AW:0]   rq2_wptr = '0;
    logic [AW:0]   ae_thresh = '0;
    logic [AW:0]   rptr_gray;
    logic [AW-1:0] r_addr;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   r_level;
    logic          underflow;

    rptr_empty_level #(.ADDR_WIDTH(AW)) dut (
        .r_clk(r_clk), .r_rstn(r_rstn), .r_en(r_en), .rq2_wptr(rq2_wptr),
        .ae_thresh(ae_thresh), .clr_uflow(clr_uflow), .rptr_gray(rptr_gray),
        .r_addr(r_addr), .empty(empty), .almost_empty(almost_empty),
        .r_level(r_level), .underflow(underflow)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic        en;
        logic [4:0]  wp;
        logic [4:0]  th;
        logic        clr;
        logic [4:0]  gray;
        logic [3:0]  addr;
        logic        emp;
        logic        ae;
        logic [4:0]  lvl;
        logic        uf;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[10];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic en, input logic [4:0] wp, input logic [4:0] th,
                                input logic clr, input logic [4:0] gray, input logic [3:0] addr,
                                input logic emp, input logic ae, input logic [4:0] lvl,
                                input logic uf);
        vec_t v;
        v.en = en; v.wp = wp; v.th = th; v.clr = clr; v.gray = gray;
        v.addr = addr; v.emp = emp; v.ae = ae; v.lvl = lvl; v.uf = uf;
        return v;
    endfunction

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic compare_out(input vec_t e, input string nm);
        chk({nm, " rptr_gray"},    32'(rptr_gray),    32'(e.gray));
        chk({nm, " r_addr"},       32'(r_addr),       32'(e.addr));
        chk({nm, " empty"},        32'(empty),        32'(e.emp));
        chk({nm, " almost_empty"}, 32'(almost_empty), 32'(e.ae));
        chk({nm, " r_level"},      32'(r_level),      32'(e.lvl));
        chk({nm, " underflow"},    32'(underflow),    32'(e.uf));
    endtask

    task automatic check_reset(input string nm);
        compare_out(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0), nm);
    endtask

    // Expected result is queued with the stimulus and retired one edge later.
    task automatic apply(input vec_t v, input string nm);
        exp_q.push_back(v);
        r_en = v.en; rq2_wptr = v.wp; ae_thresh = v.th; clr_uflow = v.clr;
        @(posedge r_clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", nm);
        end else begin
            compare_out(exp_q.pop_front(), nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] b;
        //           en  wptr      thr  clr gray      addr emp ae lvl uf
        tbl[0] = mk(1'b0, 5'b00010, 5'd2, 1'b0, 5'b00000, 4'd0, 1'b0, 1'b0, 5'd3, 1'b0);
        tbl[1] = mk(1'b1, 5'b00010, 5'd2, 1'b0, 5'b00001, 4'd1, 1'b0, 1'b1, 5'd2, 1'b0);
        tbl[2] = mk(1'b1, 5'b00010, 5'd2, 1'b0, 5'b00011, 4'd2, 1'b0, 1'b1, 5'd1, 1'b0);
        tbl[3] = mk(1'b1, 5'b00010, 5'd2, 1'b0, 5'b00010, 4'd3, 1'b1, 1'b1, 5'd0, 1'b0);
        tbl[4] = mk(1'b1, 5'b00010, 5'd2, 1'b0, 5'b00010, 4'd3, 1'b1, 1'b1, 5'd0, 1'b1);
        tbl[5] = mk(1'b1, 5'b00010, 5'd2, 1'b1, 5'b00010, 4'd3, 1'b1, 1'b1, 5'd0, 1'b1);
        tbl[6] = mk(1'b0, 5'b00010, 5'd2, 1'b1, 5'b00010, 4'd3, 1'b1, 1'b1, 5'd0, 1'b0);
        tbl[7] = mk(1'b0, 5'b00010, 5'd2, 1'b0, 5'b00010, 4'd3, 1'b1, 1'b1, 5'd0, 1'b0);
        tbl[8] = mk(1'b0, 5'b00110, 5'd0, 1'b0, 5'b00010, 4'd3, 1'b0, 1'b0, 5'd1, 1'b0);
        tbl[9] = mk(1'b1, 5'b00110, 5'd0, 1'b0, 5'b00110, 4'd4, 1'b1, 1'b1, 5'd0, 1'b0);

        // Asynchronous reset before any clock edge, with a live write pointer and read request.
        rq2_wptr = 5'b11000; r_en = 1'b1;
        #2 r_rstn = 1'b0;
        #1 check_reset("async_rst");
        repeat (2) @(posedge r_clk);
        #1 check_reset("rst_held");
        r_en = 1'b0; rq2_wptr = 5'b00010; ae_thresh = 5'd2; r_rstn = 1'b1;

        for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Full FIFO, then reset pulsed in the middle of the fifth read.
        r_rstn = 1'b0;
        r_en = 1'b0; rq2_wptr = 5'b11000; ae_thresh = 5'd15;
        @(posedge r_clk);
        #1 r_rstn = 1'b1;
        apply(mk(1'b0, 5'b11000, 5'd15, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 5'd16, 1'b0), "full_t15");
        apply(mk(1'b0, 5'b11000, 5'd16, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, 5'd16, 1'b0), "full_t16");
        for (int k = 1; k <= 4; k++)
            apply(mk(1'b1, 5'b11000, 5'd15, 1'b0, g(5'(k)), 4'(k), 1'b0, 1'b1, 5'(16 - k), 1'b0),
                  $sformatf("full_rd%0d", k));
        r_en = 1'b1;
        #3 r_rstn = 1'b0;
        #1 check_reset("mid_rst");
        r_en = 1'b0;
        @(posedge r_clk);
        #1 r_rstn = 1'b1;
        apply(mk(1'b0, 5'b11000, 5'd15, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 5'd16, 1'b0), "post_rst");

        // Drain to 16, advance writer to 30, drain to 30, then wrap the writer past zero.
        for (int k = 1; k <= 16; k++)
            apply(mk(1'b1, 5'b11000, 5'd15, 1'b0, g(5'(k)), 4'(k), k == 16, 1'b1, 5'(16 - k), 1'b0),
                  $sformatf("drain%0d", k));
        apply(mk(1'b0, 5'b10001, 5'd2, 1'b0, 5'b11000, 4'd0, 1'b0, 1'b0, 5'd14, 1'b0), "w30");
        for (int k = 1; k <= 14; k++)
            apply(mk(1'b1, 5'b10001, 5'd2, 1'b0, g(5'(16 + k)), 4'(k), k == 14, (14 - k) <= 2,
                     5'(14 - k), 1'b0), $sformatf("to30_%0d", k));
        apply(mk(1'b0, 5'b00011, 5'd2, 1'b0, 5'b10001, 4'd14, 1'b0, 1'b0, 5'd4, 1'b0), "wrap_lvl4");
        for (int k = 1; k <= 4; k++) begin
            b = 5'(30 + k);
            apply(mk(1'b1, 5'b00011, 5'd2, 1'b0, g(b), b[3:0], k == 4, (4 - k) <= 2, 5'(4 - k), 1'b0),
                  $sformatf("wrap_rd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rptr_empty_level.md
RPTR_EMPTY_LEVEL -- requirements
Module: rptr_empty_level

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, memory address width; FIFO depth is 2^ADDR_WIDTH and pointers are ADDR_WIDTH+1 bits.
REQ-002 r_clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 r_rstn  input  1  asynchronous, active-low reset.
REQ-004 r_en  input  1  read request from the consumer.
REQ-005 rq2_wptr  input  ADDR_WIDTH+1  write pointer (Gray), already synchronised into r_clk.
REQ-006 ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold in words; quasi-static.
REQ-007 clr_uflow  input  1  clears the sticky underflow flag.
REQ-008 rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
REQ-009 r_addr  output  ADDR_WIDTH  memory read address, equal to rptr_bin[ADDR_WIDTH-1:0].
REQ-010 empty  output  1  registered empty flag.
REQ-011 almost_empty  output  1  registered flag: level <= ae_thresh.
REQ-012 r_level  output  ADDR_WIDTH+1  registered read-side fill level, 0..2^ADDR_WIDTH.
REQ-013 underflow  output  1  sticky flag for a read attempted while empty.

Function
REQ-014 rd_fire SHALL be r_en & ~empty, using the registered empty; a read attempted while empty SHALL NOT move any pointer.
REQ-015 rptr_bin_nxt SHALL be rptr_bin + rd_fire, wrapping modulo 2^(ADDR_WIDTH+1).
REQ-016 rptr_gray_nxt SHALL be rptr_bin_nxt ^ (rptr_bin_nxt >> 1).
REQ-017 Both rptr_bin and rptr_gray SHALL register their next values every cycle.
REQ-018 rptr_gray SHALL change by at most one bit per cycle.
REQ-019 wbin SHALL be the combinational Gray-to-binary conversion of rq2_wptr, computed MSB-first as a prefix XOR.
REQ-020 level_nxt SHALL be wbin - rptr_bin_nxt, modulo 2^(ADDR_WIDTH+1); r_level SHALL register level_nxt.
REQ-021 empty SHALL register (rptr_gray_nxt == rq2_wptr), so the flag deasserts 1 cycle after rq2_wptr changes.
REQ-022 empty SHALL assert on the same edge that consumes the last word.
REQ-023 almost_empty SHALL register (level_nxt <= ae_thresh), as an unsigned compare.
REQ-024 If ae_thresh >= 2^ADDR_WIDTH, almost_empty SHALL stay 1.
REQ-025 If ae_thresh = 0, almost_empty SHALL equal empty.
REQ-026 underflow SHALL set on any edge where r_en & empty, and SHALL clear on an edge where clr_uflow=1 and there is no set condition.
REQ-027 When set and clear coincide, set SHALL win.
REQ-028 A full FIFO (wbin - rptr_bin = 2^ADDR_WIDTH, MSBs differ and lower bits equal) SHALL report r_level = 2^ADDR_WIDTH, empty=0 and almost_empty=0 when ae_thresh < 2^ADDR_WIDTH.
REQ-029 No combinational path SHALL exist from r_en to empty, almost_empty, r_level or underflow.

Reset
REQ-030 On r_rstn=0, at once and regardless of r_clk, the block SHALL set rptr_bin=0 and rptr_gray=0, which makes r_addr=0.
REQ-031 On r_rstn=0 the block SHALL also set empty=1, almost_empty=1, r_level=0 and underflow=0.
REQ-032 Reset asserted mid-read SHALL discard the read in flight.
REQ-033 After reset releases, the first edge SHALL evaluate normally against the current rq2_wptr.

Verification (ADDR_WIDTH=4)
REQ-034 Reset: assert r_rstn=0 with rq2_wptr=5'b11000 and r_en=1 -> rptr_gray=0, r_addr=0, empty=1, almost_empty=1, r_level=0, underflow=0, with no clock edge needed.
REQ-035 Basic: hold rptr=0, drive rq2_wptr=5'b00010 (bin 3) and ae_thresh=2 -> after 1 edge, empty=0, r_level=3, almost_empty=0.
REQ-036 Basic, continued: hold r_en=1 for 3 cycles -> r_addr goes 0,1,2 and rptr_gray goes 00001,00011,00010; r_level goes 2,1,0; almost_empty=1 after the first read; empty=1 after the third read.
REQ-037 Underflow: with empty=1, pulse r_en for 1 cycle -> underflow=1 and rptr_gray unchanged; then clr_uflow=1 together with r_en=1 -> underflow stays 1; then clr_uflow alone -> underflow=0.
REQ-038 Wrap: set rptr_bin=30 (rptr_gray=10001, reached via reads), then drive rq2_wptr=5'b00011 (bin 2) -> r_level=4.
REQ-039 Wrap, continued: read 4 words -> r_addr goes 14,15,0,1 and rptr_gray goes 10000,00000,00001,00011; then empty=1 and r_level=0.
REQ-040 Full and mid-reset: with rptr=0, drive rq2_wptr=5'b11000 (bin 16) -> r_level=16, empty=0, almost_empty=0 at ae_thresh=15 and 1 at ae_thresh=16; reading continuously and pulsing r_rstn low at the 5th read -> all outputs return to their reset values at once.
